// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input reorder block.
//   FFT_N        default log2 of the number of FFT points
//   FFT_POINTS   default number of FFT points
//   FFT_DATA_W   default sample width
//   bank_state_e per-bank FILL/DRAIN encoding
//   bitrev()     reverses the low n bits of a value
package fft_pkg;

  localparam int FFT_N      = 3;
  localparam int FFT_POINTS = 1 << FFT_N;
  localparam int FFT_DATA_W = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } bank_state_e;

  // Shifts bits out of the LSB end of v and into the LSB end of the result,
  // so after n steps the low n bits appear in reverse order.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
    logic [31:0] r_acc;
    logic [31:0] r_src;
    r_acc = '0;
    r_src = v;
    for (int i = 0; i < n; i++) begin
      r_acc = {r_acc[30:0], r_src[0]};
      r_src = r_src >> 1;
    end
    return r_acc;
  endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Combinational N-bit bit reversal.
// Ports:
//   i_val  N-bit input value
//   o_rev  i_val with its bit order reversed
module fft_bitrev
  import fft_pkg::*;
#(
  parameter int N = FFT_N
) (
  input  logic [N-1:0] i_val,
  output logic [N-1:0] o_rev
);

  assign o_rev = N'(bitrev(32'(i_val), N));

endmodule

// File: rtl/fft_input_reorder.sv
// Reorders a natural-order sample stream into bit-reversed order for an
// in-place radix-2 FFT. Samples are written at natural addresses and read
// back at bitrev(rd_cnt).
//
// Build option: define FFT_REORDER_PINGPONG_EN for two banks so one frame
// can fill while the previous one drains; otherwise a single bank refuses
// input while it drains.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream sample present
//   in_ready   block accepts a sample this cycle
//   in_data    sample, natural order
//   out_valid  reordered sample present
//   out_ready  downstream accepts
//   out_data   sample, bit-reversed order
//   out_index  natural index of the sample on out_data
//   out_last   final sample of a frame
//
// Per-bank states:
//   state | meaning
//   FILL  | bank is accepting samples at wr_cnt
//   DRAIN | bank holds a full frame, emitting at bitrev(rd_cnt)
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [N-1:0]      out_index,
  output logic              out_last
);

  localparam int          PTS  = 1 << N;
  localparam logic [N-1:0] LAST = N'(PTS - 1);

`ifdef FFT_REORDER_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  bank_state_e       r_state     [NBANK];
  bank_state_e       w_state_nxt [NBANK];
  logic [DATA_W-1:0] r_mem       [NBANK][PTS];

  logic [N-1:0] r_wr_cnt;
  logic [N-1:0] r_rd_cnt;
  logic [N-1:0] w_rd_addr;
  logic         w_wr_bank;
  logic         w_rd_bank;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_in_acc;
  logic         w_out_hs;
  logic         w_wr_wrap;
  logic         w_rd_wrap;

  fft_bitrev #(.N(N)) u_bitrev (
    .i_val (r_rd_cnt),
    .o_rev (w_rd_addr)
  );

`ifdef FFT_REORDER_PINGPONG_EN
  logic r_wr_bank;
  logic r_rd_bank;

  // Write and read sides each advance to the other bank when their frame
  // boundary is crossed; the two toggles are independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_wr_wrap) r_wr_bank <= ~r_wr_bank;
      if (w_rd_wrap) r_rd_bank <= ~r_rd_bank;
    end
  end

  assign w_wr_bank = r_wr_bank;
  assign w_rd_bank = r_rd_bank;
`else
  assign w_wr_bank = 1'b0;
  assign w_rd_bank = 1'b0;
`endif

  // Readiness depends only on registered state, never on in_valid/out_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state[w_wr_bank] == FILL);
    w_out_valid = (r_state[w_rd_bank] == DRAIN);
    w_in_acc    = in_valid && w_in_ready;
    w_out_hs    = w_out_valid && out_ready;
    w_wr_wrap   = w_in_acc && (r_wr_cnt == LAST);
    w_rd_wrap   = w_out_hs && (r_rd_cnt == LAST);
    // The write bank is in FILL and the read bank in DRAIN whenever these
    // fire, so when both fire they address different banks.
    if (w_wr_wrap) w_state_nxt[w_wr_bank] = DRAIN;
    if (w_rd_wrap) w_state_nxt[w_rd_bank] = FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBANK; i++) r_state[i] <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_in_acc) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_out_hs) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  // Sample storage is not reset; a discarded partial frame is simply
  // overwritten by the next one.
  always_ff @(posedge clk) begin
    if (!rst && w_in_acc) r_mem[w_wr_bank][r_wr_cnt] <= in_data;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_index = w_out_valid ? w_rd_addr : '0;
  assign out_data  = w_out_valid ? r_mem[w_rd_bank][w_rd_addr] : '0;
  assign out_last  = w_out_valid && (r_rd_cnt == LAST);

endmodule

// File: tb/tb_fft_input_reorder.sv
module tb_fft_input_reorder;

  typedef logic [7:0] frame_t [8];

`ifdef FFT_REORDER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_index;
  logic       out_last;

  int total = 0;
  int bad   = 0;

  // Reference model: frames being collected and full frames waiting to drain.
  logic [7:0] fillq[$];
  frame_t     fullq[$];
  int         pos = 0;
  bit         chk_rst = 0;

  fft_input_reorder #(.N(3), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic int rev3(input int p);
    int r = 0;
    int x = p;
    for (int k = 0; k < 3; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input bit ordy);
    bit exp_ir, exp_ov, acc, hs;
    int idx;
    frame_t f;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    exp_ir = (fullq.size() < CAP);
    exp_ov = (fullq.size() > 0);
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        idx = rev3(pos);
        chk("out_data", 32'(out_data), 32'(fullq[0][idx]));
        chk("out_index", 32'(out_index), 32'(idx));
        chk("out_last", 32'(out_last), 32'(pos == 7));
      end else begin
        chk("out_last_idle", 32'(out_last), 32'(0));
      end
      if (chk_rst) begin
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_index", 32'(out_index), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
      end
    end
    acc = v && exp_ir && !rst;
    hs  = exp_ov && ordy && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      fillq.delete();
      fullq.delete();
      pos = 0;
    end else begin
      if (hs) begin
        pos++;
        if (pos == 8) begin
          pos = 0;
          void'(fullq.pop_front());
        end
      end
      if (acc) begin
        fillq.push_back(d);
        if (fillq.size() == 8) begin
          for (int i = 0; i < 8; i++) f[i] = fillq[i];
          fullq.push_back(f);
          fillq.delete();
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1, 8'hAA, 0);
    tick(1, 8'hAB, 1);
    rst = 1'b0;
    chk_rst = 1;
    tick(0, 8'h00, 0);
    chk_rst = 0;
  endtask

  task automatic feed(input int base, input int cnt, input bit ordy);
    for (int i = 0; i < cnt; i++) tick(1, 8'(base + i), ordy);
  endtask

  task automatic drain();
    int c = 0;
    while (fullq.size() > 0 && c < 200) begin
      tick(0, 8'h00, 1);
      c++;
    end
    if (fullq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout observed=%0d frames left expected=0", fullq.size());
    end
  endtask

  initial begin
    int stall;
    int c;
    do_reset();

    // Natural-order frame 0..7 straight through.
    feed(0, 8, 1);
    drain();

    // Back-pressure for three cycles while the third output is presented.
    feed(0, 8, 1);
    stall = 0;
    c = 0;
    while (fullq.size() > 0 && c < 200) begin
      if (pos == 2 && stall < 3) begin
        stall++;
        tick(0, 8'h00, 0);
      end else begin
        tick(0, 8'h00, 1);
      end
      c++;
    end
    chk("stall_cycles", 32'(stall), 32'(3));

    // Reset mid-frame discards the partial frame.
    feed(0, 5, 1);
    do_reset();
    feed(10, 8, 1);
    drain();

    // Inputs offered continuously during the drain.
    feed(20, 8, 1);
    for (int i = 0; i < 10; i++) tick(1, 8'd99, 1);
    drain();
    do_reset();

    // Two frames back to back with the output always ready.
    feed(0, 16, 1);
    drain();

    // Two frames offered with the output stalled, then released.
    feed(32, 16, 0);
    for (int i = 0; i < 4; i++) tick(1, 8'd77, 0);
    drain();
    do_reset();

    // Random traffic on both sides.
    for (int i = 0; i < 400; i++)
      tick(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
